dmx_tx_engine: RTL
==================

DMX_TX_ENGINE -- requirements
Module: dmx_tx_engine

Interface
REQ-001 SHALL provide parameter CLK_HZ, default 12_000_000, system clock frequency in Hz.
REQ-002 SHALL provide parameter BAUD, default 250_000, DMX bit rate; CLK_HZ/BAUD SHALL be an integer >= 2 (DIV).
REQ-003 SHALL provide parameter NUM_CHANNELS, default 2, number of universes transmitted in lockstep (1..8).
REQ-004 SHALL provide parameters BREAK_BITS = 25, MAB_BITS = 3, IDLE_BITS = 2, START_CODE = 8'h00.
REQ-005 SHALL have port CLK12  in  1  system clock, all logic on rising edge.
REQ-006 SHALL have port RST  in  1  reset, asynchronous, active-high.
REQ-007 SHALL have port enable  in  1  frame start permission; sampled only in IDLE.
REQ-008 SHALL have port slot_limit  in  10  data slots per frame; clamped to 1..512; latched on entry to BREAK.
REQ-009 SHALL have port slot_bytes  in  8*NUM_CHANNELS  byte for channel c on bits [8c+7:8c].
REQ-010 SHALL have port slot_count  out  10  index of the slot whose bytes are sampled at the next load.
REQ-011 SHALL have port dmx_data  out  NUM_CHANNELS  registered serial line per channel, 1 = mark.
REQ-012 SHALL have port frame_done  out  1  one-cycle pulse when the last slot's final stop bit ends.
REQ-013 SHALL have port busy  out  1  high in every state except IDLE.
REQ-014 SHALL have port DEBUG  out  8  debug bus, see Configuration.

Function
REQ-015 SHALL generate a bit tick every DIV cycles from a down-counter reloaded to DIV-1; all state/data changes occur only on tick cycles.
REQ-016 SHALL implement states IDLE, BREAK, MAB, SLOTS, MARK_AFTER; each holds for a bit count loaded on entry.
REQ-017 IDLE: dmx_data all 1; on a tick with enable=1 SHALL enter BREAK, latch clamped slot_limit, and set slot_count=0; with enable=0 SHALL remain in IDLE.
REQ-018 BREAK: dmx_data all 0 for exactly BREAK_BITS ticks, then MAB.
REQ-019 MAB: dmx_data all 1 for exactly MAB_BITS ticks, then SLOTS with the shifter loaded with START_CODE on every channel and slot_count=1.
REQ-020 SLOTS: each slot SHALL be 11 ticks: start bit 0, eight data bits LSB first, two stop bits 1.
REQ-021 On the tick ending a slot's second stop bit, if slot_count <= latched limit, the block SHALL load all channel shifters from slot_bytes and increment slot_count; otherwise it SHALL enter MARK_AFTER.
REQ-022 slot_bytes SHALL be sampled only on the load tick; slot_count SHALL remain stable for a full slot time (11*DIV cycles) before that sample.
REQ-023 MARK_AFTER: dmx_data all 1 for IDLE_BITS ticks, then IDLE; frame_done SHALL pulse on the cycle IDLE is entered; slot_count SHALL return to 0.
REQ-024 Frame length in ticks SHALL be BREAK_BITS + MAB_BITS + 11*(limit+1) + IDLE_BITS.
REQ-025 slot_limit of 0 SHALL be treated as 1; values > 512 SHALL be treated as 512.
REQ-026 Changes on enable or slot_limit mid-frame SHALL NOT affect the frame in progress.
REQ-027 All channels SHALL share state and timing; only the data bits differ.

Reset
REQ-028 While RST=1: state IDLE, bit counter 0, baud counter 0, slot_count 0, dmx_data all 1, frame_done 0, busy 0, shifters 9'h1FF.
REQ-029 Assertion mid-frame SHALL force outputs to reset values immediately; after release, the first frame SHALL begin with a full BREAK.

Configuration
REQ-030 Macro DMX_TX_ENGINE_DEBUG_EN: when defined, DEBUG = {bit_count[4:0], state[2:1] coded, dmx_data[0]}; when undefined, DEBUG SHALL be driven 8'h00 and no debug logic retained.

Verification
REQ-031 Defaults, slot_limit=4, enable=1 after reset -> channel 0 low for 1200 cycles, high 144, five 528-cycle slots, high 96; frame_done 4080 cycles after BREAK start.
REQ-032 slot_bytes ch0=8'hA5, ch1=8'h3C during slot 1 -> ch0 bits 0,1,0,1,0,0,1,0,1,1,1; ch1 bits 0,0,0,1,1,1,1,0,0,1,1.
REQ-033 slot_limit=0, then 600 -> frames of 2 slots (limit 1) and 513 slots (limit 512); slot_count peaks at 2 and 513.
REQ-034 enable dropped mid-frame -> current frame completes, frame_done pulses, line stays high, busy=0; enable re-raised -> BREAK starts on next tick.
REQ-035 RST pulsed during slot 3 -> dmx_data all 1 and slot_count 0 same cycle; next frame starts with 25-bit BREAK.
REQ-036 BAUD=125_000, NUM_CHANNELS=1, DMX_TX_ENGINE_DEBUG_EN defined -> 96 cycles per bit; DEBUG[0] tracks dmx_data[0].

Source files
------------

// File: rtl/dmx_tx_engine.sv
// DMX512 transmitter: BREAK / MAB / slot stream / mark-after, NUM_CHANNELS universes in lockstep.
// Optional debug bus enabled by defining DMX_TX_ENGINE_DEBUG_EN.
module dmx_tx_engine #(
  parameter int unsigned CLK_HZ       = 12_000_000,
  parameter int unsigned BAUD         = 250_000,
  parameter int unsigned NUM_CHANNELS = 2,
  parameter int unsigned BREAK_BITS   = 25,
  parameter int unsigned MAB_BITS     = 3,
  parameter int unsigned IDLE_BITS    = 2,
  parameter logic [7:0]  START_CODE   = 8'h00
) (
  input  logic                        CLK12,
  input  logic                        RST,
  input  logic                        enable,
  input  logic [9:0]                  slot_limit,
  input  logic [8*NUM_CHANNELS-1:0]   slot_bytes,
  output logic [9:0]                  slot_count,
  output logic [NUM_CHANNELS-1:0]     dmx_data,
  output logic                        frame_done,
  output logic                        busy,
  output logic [7:0]                  DEBUG
);

  localparam int unsigned DIV    = CLK_HZ / BAUD;
  localparam int unsigned BAUD_W = (DIV > 2) ? $clog2(DIV) : 1;
  localparam int unsigned BIT_W  = 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'b000,
    ST_BREAK = 3'b010,
    ST_MAB   = 3'b011,
    ST_SLOTS = 3'b100,
    ST_MARK  = 3'b110
  } state_t;

  state_t                         state_q;
  logic [BAUD_W-1:0]              baud_q, baud_d;
  logic                           tick;
  logic [BIT_W-1:0]               bit_q;
  logic [9:0]                     slot_count_q;
  logic [9:0]                     limit_q;
  logic [9:0]                     limit_clamped;
  logic [NUM_CHANNELS-1:0]        dmx_q;
  logic [NUM_CHANNELS-1:0][8:0]   shift_q;
  logic                           done_q;
  logic                           busy_q;

  // Bit-rate divider: tick whenever the down-counter hits zero.
  assign tick   = (baud_q == '0);
  assign baud_d = tick ? BAUD_W'(DIV - 1) : baud_q - 1'b1;

  always_ff @(posedge CLK12 or posedge RST) begin
    if (RST) baud_q <= '0;
    else     baud_q <= baud_d;
  end

  always_comb begin
    limit_clamped = slot_limit;
    if (slot_limit == 10'd0)        limit_clamped = 10'd1;
    else if (slot_limit > 10'd512)  limit_clamped = 10'd512;
  end

  // Frame sequencer; every output change happens on a bit tick.
  always_ff @(posedge CLK12 or posedge RST) begin
    if (RST) begin
      state_q      <= ST_IDLE;
      bit_q        <= '0;
      slot_count_q <= '0;
      limit_q      <= '0;
      dmx_q        <= '1;
      shift_q      <= '1;
      done_q       <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (tick) begin
        case (state_q)
          ST_IDLE: begin
            if (enable) begin
              state_q      <= ST_BREAK;
              bit_q        <= BIT_W'(BREAK_BITS - 1);
              limit_q      <= limit_clamped;
              slot_count_q <= '0;
              dmx_q        <= '0;
              busy_q       <= 1'b1;
            end
          end
          ST_BREAK: begin
            if (bit_q == '0) begin
              state_q <= ST_MAB;
              bit_q   <= BIT_W'(MAB_BITS - 1);
              dmx_q   <= '1;
            end else begin
              bit_q <= bit_q - 1'b1;
            end
          end
          ST_MAB: begin
            if (bit_q == '0) begin
              state_q      <= ST_SLOTS;
              bit_q        <= BIT_W'(10);
              slot_count_q <= 10'd1;
              dmx_q        <= '0;
              for (int c = 0; c < int'(NUM_CHANNELS); c++) shift_q[c] <= {1'b1, START_CODE};
            end else begin
              bit_q <= bit_q - 1'b1;
            end
          end
          ST_SLOTS: begin
            // bit_q 10..3 emit data, 2..1 stop bits, 0 ends the slot.
            if (bit_q == '0) begin
              if (slot_count_q <= limit_q) begin
                bit_q        <= BIT_W'(10);
                slot_count_q <= slot_count_q + 10'd1;
                dmx_q        <= '0;
                for (int c = 0; c < int'(NUM_CHANNELS); c++) shift_q[c] <= {1'b1, slot_bytes[8*c +: 8]};
              end else begin
                state_q <= ST_MARK;
                bit_q   <= BIT_W'(IDLE_BITS - 1);
                dmx_q   <= '1;
              end
            end else begin
              bit_q <= bit_q - 1'b1;
              for (int c = 0; c < int'(NUM_CHANNELS); c++) begin
                dmx_q[c]   <= shift_q[c][0];
                shift_q[c] <= {1'b1, shift_q[c][8:1]};
              end
            end
          end
          ST_MARK: begin
            if (bit_q == '0) begin
              state_q      <= ST_IDLE;
              slot_count_q <= '0;
              done_q       <= 1'b1;
              busy_q       <= 1'b0;
              dmx_q        <= '1;
            end else begin
              bit_q <= bit_q - 1'b1;
            end
          end
          default: begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            dmx_q   <= '1;
          end
        endcase
      end
    end
  end

  assign slot_count = slot_count_q;
  assign dmx_data   = dmx_q;
  assign frame_done = done_q;
  assign busy       = busy_q;

`ifdef DMX_TX_ENGINE_DEBUG_EN
  assign DEBUG = {bit_q[4:0], state_q[2:1], dmx_q[0]};
`else
  assign DEBUG = 8'h00;
`endif

endmodule
